// File: rtl/shift_add_pkg.sv
// Shared FSM encoding and datapath step selectors for the shift-add multiplier.
// Pure declarations: no logic, no latency, no flow control.
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic STEP_ADD = 1'b0;
  localparam logic STEP_SUB = 1'b1;

endpackage

// File: rtl/shift_add_step.sv
// One shift-add iteration: conditionally add/subtract mcand into the high half, then shift right.
// Purely combinational (zero latency); no flow control.
module shift_add_step
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic             i_last,
  input  logic             i_signed,
  output logic [2*WIDTH:0] o_acc
);

  logic [WIDTH:0] w_hi;
  logic [WIDTH:0] w_mext;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_hi_nxt;
  logic           w_op;
  logic           w_fill;

  always_comb begin
    w_hi     = i_acc[2*WIDTH:WIDTH];
    w_mext   = {i_signed & i_mcand[WIDTH-1], i_mcand};
    // The multiplier's sign bit carries negative weight, so its partial product is subtracted.
    w_op     = (i_signed & i_last) ? STEP_SUB : STEP_ADD;
    w_sum    = (w_op == STEP_SUB) ? (w_hi - w_mext) : (w_hi + w_mext);
    w_hi_nxt = i_acc[0] ? w_sum : w_hi;
    w_fill   = i_signed & w_hi_nxt[WIDTH];
    o_acc    = {w_fill, w_hi_nxt, i_acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_add_multi_seq.sv
// Sequential WIDTH x WIDTH shift-add multiplier, one multiplier bit per clock; WIDTH cycles accept->out_valid.
// Result held until out_ready; new operands accepted in IDLE or in DONE while the result drains. SHIFT_ADD_SIGNED_EN selects two's complement.
module shift_add_multi_seq
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

`ifdef SHIFT_ADD_SIGNED_EN
  localparam logic SIGNED_MODE = 1'b1;
`else
  localparam logic SIGNED_MODE = 1'b0;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH:0]   r_acc;
  logic [2*WIDTH:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_out;
  logic               w_last;
  logic               w_accept;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_last   (w_last),
    .i_signed (SIGNED_MODE),
    .o_acc    (w_acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = in_valid ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    out_valid = (r_state == DONE);
    busy      = (r_state == CALC);
    w_accept  = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else if (w_accept) begin
      r_mcand <= a;
      r_acc   <= {{(WIDTH+1){1'b0}}, b};
      r_cnt   <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_out <= w_acc_nxt[2*WIDTH-1:0];
      end
    end
  end

  assign out = r_out;

endmodule
